bp_lce_req_tx: RTL and testbench

BP_LCE_REQ_TX -- requirements
Module: bp_lce_req_tx

---
 rtl/bp_lce_req_tx.sv | 197 +++++++++++++++++++
 tb/tb_bp_lce_req_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_lce_req_tx.sv
// LCE request transmitter: accepts one cache-miss request at a time, builds a
// BedRock LCE request header, presents it to the network under a credit-based
// flow control scheme, and (for cacheable misses) waits for the fill to finish.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   lce_id_i                source LCE id written into payload.src_id
//   miss_*                  miss request channel (valid/ready-and handshake)
//   lce_req_header_o/v_o    registered header + valid toward the network
//   lce_req_ready_and_i     network ready
//   credit_return_i         one network credit returned this cycle
//   fill_done_i             cacheable miss completed
//   credits_empty_o/full_o  credit counter status
//   credit_overflow_o       sticky: credit returned while counter was full

package bp_lce_req_tx_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  // Widths of the default processor configuration
  localparam int unsigned paddr_width_p     = 40;
  localparam int unsigned lce_id_width_p    = 4;
  localparam int unsigned cce_id_width_p    = 4;
  localparam int unsigned lce_assoc_p       = 8;
  localparam int unsigned lce_assoc_width_p = $clog2(lce_assoc_p);

  typedef enum logic [3:0] {
    e_bedrock_req_rd    = 4'd0,
    e_bedrock_req_wr    = 4'd1,
    e_bedrock_req_uc_rd = 4'd2,
    e_bedrock_req_uc_wr = 4'd3
  } bp_bedrock_req_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef enum logic {
    e_bedrock_req_excl     = 1'b0,
    e_bedrock_req_non_excl = 1'b1
  } bp_bedrock_req_non_excl_e;

  typedef struct packed {
    logic [cce_id_width_p-1:0]    dst_id;
    logic [lce_id_width_p-1:0]    src_id;
    bp_bedrock_req_non_excl_e     non_exclusive;
    logic [lce_assoc_width_p-1:0] lru_way_id;
  } bp_bedrock_lce_req_payload_s;

  typedef struct packed {
    bp_bedrock_req_type_e         msg_type;
    logic [paddr_width_p-1:0]     addr;
    bp_bedrock_msg_size_e         size;
    bp_bedrock_lce_req_payload_s  payload;
  } bp_bedrock_lce_req_msg_header_s;

  localparam int unsigned lce_req_msg_header_width_lp = $bits(bp_bedrock_lce_req_msg_header_s);

endpackage

module bp_lce_req_tx
  import bp_lce_req_tx_pkg::*;
#(
  parameter bp_params_e  bp_params_p = e_bp_default_cfg,
  parameter int unsigned credits_p   = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [lce_id_width_p-1:0]              lce_id_i,

  input  logic                                   miss_v_i,
  output logic                                   miss_ready_and_o,
  input  logic [1:0]                             miss_type_i,
  input  logic [paddr_width_p-1:0]               miss_addr_i,
  input  bp_bedrock_msg_size_e                   miss_size_i,
  input  logic [lce_assoc_width_p-1:0]           miss_lru_way_i,
  input  logic                                   miss_non_excl_i,
  input  logic [cce_id_width_p-1:0]              miss_dst_id_i,

  output logic [lce_req_msg_header_width_lp-1:0] lce_req_header_o,
  output logic                                   lce_req_v_o,
  input  logic                                   lce_req_ready_and_i,

  input  logic                                   credit_return_i,
  input  logic                                   fill_done_i,
  output logic                                   credits_empty_o,
  output logic                                   credits_full_o,
  output logic                                   credit_overflow_o
);

  localparam int unsigned credit_width_lp = $clog2(credits_p + 1);
  localparam logic [credit_width_lp-1:0] credits_max_lp = credit_width_lp'(credits_p);

  // Only the default configuration's widths are modelled in the package
  if (bp_params_p != e_bp_default_cfg) begin : g_cfg_check
    $error("bp_lce_req_tx: unsupported bp_params_p");
  end

  typedef enum logic [1:0] {
    e_ready     = 2'd0,
    e_send      = 2'd1,
    e_wait_fill = 2'd2
  } state_e;

  state_e                         state_r, state_n;
  bp_bedrock_lce_req_msg_header_s hdr_r, hdr_n;
  logic [credit_width_lp-1:0]     credit_cnt_r, credit_cnt_n;
  logic                           overflow_r, overflow_n;
  logic                           send_hs;

  // State, header, credit counter and registered status outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r          <= e_ready;
      hdr_r            <= '0;
      credit_cnt_r     <= credits_max_lp;
      overflow_r       <= 1'b0;
      lce_req_v_o      <= 1'b0;
      miss_ready_and_o <= 1'b0;
      credits_full_o   <= 1'b1;
      credits_empty_o  <= 1'b0;
    end else begin
      state_r          <= state_n;
      hdr_r            <= hdr_n;
      credit_cnt_r     <= credit_cnt_n;
      overflow_r       <= overflow_n;
      lce_req_v_o      <= (state_n == e_send);
      // Ready is the registered form of "idle with a credit available"
      miss_ready_and_o <= (state_n == e_ready) && (credit_cnt_n != '0);
      credits_full_o   <= (credit_cnt_n == credits_max_lp);
      credits_empty_o  <= (credit_cnt_n == '0);
    end
  end

  // Next-state, header capture and credit accounting
  always_comb begin
    state_n      = state_r;
    hdr_n        = hdr_r;
    credit_cnt_n = credit_cnt_r;
    overflow_n   = overflow_r;
    send_hs      = 1'b0;

    unique case (state_r)
      e_ready: begin
        if (miss_v_i && miss_ready_and_o) begin
          hdr_n.msg_type           = bp_bedrock_req_type_e'(4'(miss_type_i));
          hdr_n.addr               = miss_addr_i;
          hdr_n.size               = miss_size_i;
          hdr_n.payload.dst_id     = miss_dst_id_i;
          hdr_n.payload.src_id     = lce_id_i;
          hdr_n.payload.lru_way_id = miss_lru_way_i;
          // Non-exclusive only makes sense for cacheable reads
          hdr_n.payload.non_exclusive = (miss_non_excl_i && (miss_type_i == 2'd0))
                                        ? e_bedrock_req_non_excl : e_bedrock_req_excl;
          state_n = e_send;
        end
      end
      e_send: begin
        if (lce_req_ready_and_i) begin
          send_hs = 1'b1;
          state_n = ((hdr_r.msg_type == e_bedrock_req_rd) || (hdr_r.msg_type == e_bedrock_req_wr))
                    ? e_wait_fill : e_ready;
        end
      end
      e_wait_fill: begin
        if (fill_done_i) begin
          state_n = e_ready;
        end
      end
      default: state_n = e_ready;
    endcase

    // A send and a return in the same cycle cancel out
    if (send_hs && !credit_return_i) begin
      credit_cnt_n = credit_cnt_r - credit_width_lp'(1);
    end else if (!send_hs && credit_return_i) begin
      if (credit_cnt_r == credits_max_lp) begin
        overflow_n = 1'b1;
      end else begin
        credit_cnt_n = credit_cnt_r + credit_width_lp'(1);
      end
    end
  end

  assign lce_req_header_o  = hdr_r;
  assign credit_overflow_o = overflow_r;

endmodule

// File: tb/tb_bp_lce_req_tx.sv
// Directed bench for bp_lce_req_tx: reset state, cacheable/uncached misses,
// backpressure, credit exhaustion, simultaneous send/return, overflow, and
// reset during an in-flight send.

module tb_bp_lce_req_tx;
  import bp_lce_req_tx_pkg::*;

  logic                 clk;
  logic                 reset_n;
  logic [3:0]           lce_id;
  logic                 miss_v;
  logic                 miss_ready;
  logic [1:0]           miss_type;
  logic [39:0]          miss_addr;
  bp_bedrock_msg_size_e miss_size;
  logic [2:0]           miss_lru_way;
  logic                 miss_non_excl;
  logic [3:0]           miss_dst_id;
  logic [58:0]          hdr;
  logic                 req_v;
  logic                 req_ready;
  logic                 credit_return;
  logic                 fill_done;
  logic                 empty;
  logic                 full;
  logic                 overflow;

  int n_vec = 0;
  int n_err = 0;

  bp_lce_req_tx #(.bp_params_p(e_bp_default_cfg), .credits_p(8)) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .lce_id_i            (lce_id),
    .miss_v_i            (miss_v),
    .miss_ready_and_o    (miss_ready),
    .miss_type_i         (miss_type),
    .miss_addr_i         (miss_addr),
    .miss_size_i         (miss_size),
    .miss_lru_way_i      (miss_lru_way),
    .miss_non_excl_i     (miss_non_excl),
    .miss_dst_id_i       (miss_dst_id),
    .lce_req_header_o    (hdr),
    .lce_req_v_o         (req_v),
    .lce_req_ready_and_i (req_ready),
    .credit_return_i     (credit_return),
    .fill_done_i         (fill_done),
    .credits_empty_o     (empty),
    .credits_full_o      (full),
    .credit_overflow_o   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  // One uncached read with the network always ready: accept edge + send edge
  task automatic issue_uc_rd();
    miss_v    = 1'b1;
    miss_type = 2'd2;
    step();
    miss_v = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    n_vec++; if (req_v !== 1'b0)     begin n_err++; $display("FAIL reset_v: got %b want 0", req_v); end
    n_vec++; if (miss_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", miss_ready); end
    n_vec++; if (full !== 1'b1)      begin n_err++; $display("FAIL reset_full: got %b want 1", full); end
    n_vec++; if (empty !== 1'b0)     begin n_err++; $display("FAIL reset_empty: got %b want 0", empty); end
    n_vec++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_vec++; if (hdr !== 59'd0)      begin n_err++; $display("FAIL reset_hdr: got %h want 0", hdr); end
    reset_n = 1'b1;
    step();
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", miss_ready); end
  endtask

  task automatic test_rd_miss();
    logic [58:0] exp;
    exp = {4'd0, 40'h00_8000_0040, 3'd6, 4'd2, 4'd1, 1'b1, 3'd5};
    lce_id = 4'd1; miss_dst_id = 4'd2; miss_addr = 40'h00_8000_0040;
    miss_size = e_bedrock_msg_size_64; miss_lru_way = 3'd5; miss_non_excl = 1'b1;
    miss_type = 2'd0; req_ready = 1'b1; miss_v = 1'b1;
    step();
    miss_v = 1'b0;
    n_vec++; if (req_v !== 1'b1) begin n_err++; $display("FAIL rd_v: got %b want 1", req_v); end
    n_vec++; if (hdr !== exp)    begin n_err++; $display("FAIL rd_hdr: got %h want %h", hdr, exp); end
    n_vec++; if (miss_ready !== 1'b0) begin n_err++; $display("FAIL rd_ready_send: got %b want 0", miss_ready); end
    step();
    n_vec++; if (req_v !== 1'b0) begin n_err++; $display("FAIL rd_v_after_hs: got %b want 0", req_v); end
    n_vec++; if (dut.credit_cnt_r !== 4'd7) begin n_err++; $display("FAIL rd_cnt: got %0d want 7", dut.credit_cnt_r); end
    n_vec++; if (full !== 1'b0)  begin n_err++; $display("FAIL rd_full: got %b want 0", full); end
    step();
    step();
    n_vec++; if (miss_ready !== 1'b0) begin n_err++; $display("FAIL rd_wait_ready: got %b want 0", miss_ready); end
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL rd_fill_ready: got %b want 1", miss_ready); end
  endtask

  task automatic test_uc_wr_stall();
    logic [58:0] exp;
    exp = {4'd3, 40'h12_3456_7880, 3'd3, 4'd3, 4'd1, 1'b0, 3'd2};
    lce_id = 4'd1; miss_dst_id = 4'd3; miss_addr = 40'h12_3456_7880;
    miss_size = e_bedrock_msg_size_8; miss_lru_way = 3'd2; miss_non_excl = 1'b1;
    miss_type = 2'd3; req_ready = 1'b0; miss_v = 1'b1;
    step();
    miss_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (req_v !== 1'b1) begin n_err++; $display("FAIL stall_v[%0d]: got %b want 1", i, req_v); end
      n_vec++; if (hdr !== exp)    begin n_err++; $display("FAIL stall_hdr[%0d]: got %h want %h", i, hdr, exp); end
      step();
    end
    req_ready = 1'b1;
    step();
    n_vec++; if (req_v !== 1'b0)      begin n_err++; $display("FAIL uc_wr_v_after: got %b want 0", req_v); end
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL uc_wr_ready: got %b want 1", miss_ready); end
    n_vec++; if (dut.credit_cnt_r !== 4'd6) begin n_err++; $display("FAIL uc_wr_cnt: got %0d want 6", dut.credit_cnt_r); end
  endtask

  task automatic test_fill_ignored();
    apply_reset();
    miss_type = 2'd0; req_ready = 1'b0; miss_v = 1'b1;
    step();
    miss_v = 1'b0;
    fill_done = 1'b1;
    step();
    step();
    fill_done = 1'b0;
    req_ready = 1'b1;
    step();
    n_vec++; if (miss_ready !== 1'b0) begin n_err++; $display("FAIL fill_early_ready: got %b want 0", miss_ready); end
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL fill_late_ready: got %b want 1", miss_ready); end
  endtask

  task automatic test_credit_exhaust();
    apply_reset();
    req_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue_uc_rd();
    n_vec++; if (empty !== 1'b1)      begin n_err++; $display("FAIL exh_empty: got %b want 1", empty); end
    n_vec++; if (miss_ready !== 1'b0) begin n_err++; $display("FAIL exh_ready: got %b want 0", miss_ready); end
    miss_v = 1'b1;
    step();
    step();
    n_vec++; if (req_v !== 1'b0) begin n_err++; $display("FAIL exh_blocked_v: got %b want 0", req_v); end
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL ret_ready: got %b want 1", miss_ready); end
    n_vec++; if (empty !== 1'b0)      begin n_err++; $display("FAIL ret_empty: got %b want 0", empty); end
    step();
    miss_v = 1'b0;
    n_vec++; if (req_v !== 1'b1) begin n_err++; $display("FAIL ret_accept_v: got %b want 1", req_v); end
    step();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ret_empty_again: got %b want 1", empty); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    req_ready = 1'b1;
    for (int i = 0; i < 4; i++) issue_uc_rd();
    n_vec++; if (dut.credit_cnt_r !== 4'd4) begin n_err++; $display("FAIL same_pre_cnt: got %0d want 4", dut.credit_cnt_r); end
    miss_v = 1'b1; miss_type = 2'd2;
    step();
    miss_v = 1'b0;
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    n_vec++; if (dut.credit_cnt_r !== 4'd4) begin n_err++; $display("FAIL same_cnt: got %0d want 4", dut.credit_cnt_r); end
    n_vec++; if (req_v !== 1'b0)    begin n_err++; $display("FAIL same_v: got %b want 0", req_v); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL same_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    apply_reset();
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    n_vec++; if (dut.credit_cnt_r !== 4'd8) begin n_err++; $display("FAIL ovf_cnt: got %0d want 8", dut.credit_cnt_r); end
    n_vec++; if (full !== 1'b1)     begin n_err++; $display("FAIL ovf_full: got %b want 1", full); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
    for (int i = 0; i < 3; i++) step();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    apply_reset();
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_send();
    apply_reset();
    req_ready = 1'b0; miss_type = 2'd2; miss_v = 1'b1;
    step();
    miss_v = 1'b0;
    n_vec++; if (req_v !== 1'b1) begin n_err++; $display("FAIL mid_v_before: got %b want 1", req_v); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++; if (req_v !== 1'b0)      begin n_err++; $display("FAIL mid_v_async: got %b want 0", req_v); end
    n_vec++; if (miss_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_async: got %b want 0", miss_ready); end
    n_vec++; if (hdr !== 59'd0)       begin n_err++; $display("FAIL mid_hdr_async: got %h want 0", hdr); end
    step();
    req_ready = 1'b1;
    reset_n = 1'b1;
    step();
    n_vec++; if (dut.credit_cnt_r !== 4'd8) begin n_err++; $display("FAIL mid_cnt: got %0d want 8", dut.credit_cnt_r); end
    n_vec++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", miss_ready); end
    n_vec++; if (req_v !== 1'b0)      begin n_err++; $display("FAIL mid_v_after: got %b want 0", req_v); end
    n_vec++; if (full !== 1'b1)       begin n_err++; $display("FAIL mid_full: got %b want 1", full); end
  endtask

  initial begin
    reset_n = 1'b0; lce_id = '0; miss_v = 1'b0; miss_type = '0; miss_addr = '0;
    miss_size = e_bedrock_msg_size_1; miss_lru_way = '0; miss_non_excl = 1'b0;
    miss_dst_id = '0; req_ready = 1'b0; credit_return = 1'b0; fill_done = 1'b0;

    test_reset();
    test_rd_miss();
    test_uc_wr_stall();
    test_fill_ignored();
    test_credit_exhaust();
    test_same_cycle();
    test_overflow();
    test_reset_mid_send();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
